// File: rtl/decode_opc_queue_pkg.sv
// Shared types and encodings for the buffered opcode decoder: command and
// operand-form enums, flag masks and the 24-bit decoded record layout.
package decode_opc_queue_pkg;

   localparam int unsigned DECODE_REC_W = 24;

   typedef enum logic [6:0] {
      OPC_INVALID = 7'd0,
      OPC_ADD     = 7'd1,
      OPC_OR      = 7'd2,
      OPC_AND     = 7'd3,
      OPC_SUB     = 7'd4,
      OPC_XOR     = 7'd5,
      OPC_CMP     = 7'd6,
      OPC_PUSH    = 7'd7,
      OPC_POP     = 7'd8,
      OPC_JCC     = 7'd9,
      OPC_MOV     = 7'd10,
      OPC_XCHG    = 7'd11,
      OPC_BRANCH  = 7'd12,
      OPC_SETCC   = 7'd13,
      OPC_CMPXCHG = 7'd14,
      OPC_BTX     = 7'd15,
      OPC_CMOV    = 7'd16
   } opc_e;

   typedef enum logic [3:0] {
      FORM_NONE    = 4'd0,
      FORM_REG     = 4'd1,
      FORM_MR      = 4'd2,
      FORM_RM      = 4'd3,
      FORM_REG_IMM = 4'd4,
      FORM_RM_IMM  = 4'd5,
      FORM_REL     = 4'd6
   } form_e;

   // Flag bit masks, MSB first: imm_1byte .. source_is_sext
   localparam logic [8:0] FL_IMM1 = 9'h100;
   localparam logic [8:0] FL_REG1 = 9'h080;
   localparam logic [8:0] FL_R0   = 9'h040;
   localparam logic [8:0] FL_W0   = 9'h020;
   localparam logic [8:0] FL_R1   = 9'h010;
   localparam logic [8:0] FL_W1   = 9'h008;
   localparam logic [8:0] FL_R2   = 9'h004;
   localparam logic [8:0] FL_W2   = 9'h002;
   localparam logic [8:0] FL_SEXT = 9'h001;

   // Top bit is reserved and always zero.
   typedef struct packed {
      logic       rsvd;
      logic       illegal;
      logic [8:0] flags;
      logic [1:0] opnd_count;
      form_e      opnd_form;
      opc_e       opc;
   } dec_rec_t;

   function automatic dec_rec_t mk_rec(input opc_e opc, input form_e form,
                                       input logic [1:0] cnt, input logic [8:0] flags);
      dec_rec_t r;
      r.rsvd       = 1'b0;
      r.illegal    = (opc == OPC_INVALID);
      r.flags      = flags;
      r.opnd_count = cnt;
      r.opnd_form  = form;
      r.opc        = opc;
      return r;
   endfunction

endpackage

// File: rtl/decode_opc_queue_lookup.sv
// Combinational opcode map: masked opcode byte plus 0F-escape flag to the
// 24-bit decoded record. Unlisted keys decode to OPC_INVALID.
import decode_opc_queue_pkg::*;

module decode_opc_lookup (
   input  logic [7:0]              opc_byte,
   input  logic                    is_2byte,
   output logic [DECODE_REC_W-1:0] rec
);

   dec_rec_t r;

   always_comb begin
      r = mk_rec(OPC_INVALID, FORM_NONE, 2'd0, 9'h000);
      if (!is_2byte) begin
         case (opc_byte)
            8'h00:   r = mk_rec(OPC_ADD,    FORM_MR,      2'd2, FL_R0 | FL_W0 | FL_R1);
            8'h08:   r = mk_rec(OPC_OR,     FORM_MR,      2'd2, FL_R0 | FL_W0 | FL_R1);
            8'h20:   r = mk_rec(OPC_AND,    FORM_MR,      2'd2, FL_R0 | FL_W0 | FL_R1);
            8'h28:   r = mk_rec(OPC_SUB,    FORM_MR,      2'd2, FL_R0 | FL_W0 | FL_R1);
            8'h30:   r = mk_rec(OPC_XOR,    FORM_MR,      2'd2, FL_R0 | FL_W0 | FL_R1);
            8'h38:   r = mk_rec(OPC_CMP,    FORM_MR,      2'd2, FL_R0 | FL_R1);
            8'h50:   r = mk_rec(OPC_PUSH,   FORM_REG,     2'd1, FL_R0);
            8'h58:   r = mk_rec(OPC_POP,    FORM_REG,     2'd1, FL_W0);
            8'h70:   r = mk_rec(OPC_JCC,    FORM_REL,     2'd1, FL_IMM1 | FL_SEXT);
            8'h88:   r = mk_rec(OPC_MOV,    FORM_MR,      2'd2, FL_W0 | FL_R1);
            8'h90:   r = mk_rec(OPC_XCHG,   FORM_REG,     2'd2, FL_R0 | FL_W0 | FL_R1 | FL_W1);
            8'hB0:   r = mk_rec(OPC_MOV,    FORM_REG_IMM, 2'd2, FL_IMM1 | FL_REG1 | FL_W0);
            8'hB8:   r = mk_rec(OPC_MOV,    FORM_REG_IMM, 2'd2, FL_W0);
            8'hE8:   r = mk_rec(OPC_BRANCH, FORM_REL,     2'd1, 9'h000);
            default: r = mk_rec(OPC_INVALID, FORM_NONE,   2'd0, 9'h000);
         endcase
      end else begin
         case (opc_byte)
            8'h40:   r = mk_rec(OPC_CMOV,    FORM_RM,     2'd2, FL_W0 | FL_R1);
            8'h80:   r = mk_rec(OPC_JCC,     FORM_REL,    2'd1, 9'h000);
            8'h90:   r = mk_rec(OPC_SETCC,   FORM_RM,     2'd1, FL_REG1 | FL_W0);
            8'hB0:   r = mk_rec(OPC_CMPXCHG, FORM_MR,     2'd3,
                                FL_R0 | FL_W0 | FL_R1 | FL_R2 | FL_W2);
            8'hB8:   r = mk_rec(OPC_BTX,     FORM_RM_IMM, 2'd2, FL_IMM1 | FL_R0 | FL_W0);
            default: r = mk_rec(OPC_INVALID, FORM_NONE,   2'd0, 9'h000);
         endcase
      end
   end

   assign rec = r;

endmodule

// File: rtl/decode_opc_queue.sv
// Opcode decoder feeding a DEPTH-entry register FIFO with valid/ready on both
// sides, synchronous flush and a sticky illegal-opcode indicator.
import decode_opc_queue_pkg::*;

module decode_opc_queue #(
   parameter int unsigned INSTR_W = 88,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_is_2byte,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [6:0]         out_opc,
   output logic [3:0]         out_opnd_form,
   output logic [1:0]         out_opnd_count,
   output logic [8:0]         out_flags,
   output logic               out_illegal,
   output logic               illegal_seen,
   output logic [CNT_W-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DECODE_REC_W-1:0] lookup_rec;
   dec_rec_t                wr_rec;
   dec_rec_t                head;
   dec_rec_t                mem_q [DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]        count_q;
   logic                    illegal_seen_q;
   logic                    push, pop, clear;
   logic                    unused_bits;

   // Embedded-register bits are masked so e.g. 0x50..0x57 share one record.
   decode_opc_lookup u_lookup (
      .opc_byte (in_instr[7:0] & 8'hF8),
      .is_2byte (in_is_2byte),
      .rec      (lookup_rec)
   );

   assign wr_rec = dec_rec_t'(lookup_rec);

   assign in_ready  = (count_q != CNT_W'(DEPTH)) || out_ready;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign clear     = rst || flush;

   always_ff @(posedge clk) begin
      if (clear) begin
         count_q        <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         illegal_seen_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (wr_rec.illegal) illegal_seen_q <= 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_ptr_q] <= wr_rec;
   end

   assign head           = mem_q[rd_ptr_q];
   assign out_opc        = head.opc;
   assign out_opnd_form  = head.opnd_form;
   assign out_opnd_count = head.opnd_count;
   assign out_flags      = head.flags;
   assign out_illegal    = head.illegal;
   assign illegal_seen   = illegal_seen_q;
   assign count          = count_q;

   assign unused_bits = ^{in_instr[INSTR_W-1:8], head.rsvd};

endmodule
